// File: rtl/uart_pkg.sv
// Frame constants and transmitter state encoding shared by the UART transmit and receive paths.
// Keeping them in one package keeps both ends of the link agreed on the frame shape.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Even parity: the parity bit makes the total number of ones in data+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO queueing bytes for the UART transmitter.
// Read data is presented combinationally from the head entry (first-word fall-through).
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_BPS_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and count alone define
  // which entries are valid, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk_BPS_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_BPS_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: queues bytes in a FIFO and serialises them as start, 8 data bits LSB-first,
// optional even parity and STOP_BITS stop bits, one bit per clk_BPS_i edge, frames back-to-back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter int   STOP_BITS = 1,
  parameter logic PARITY_EN = 1'b0
) (
  input  logic                     clk_BPS_i,
  input  logic                     rst_i,
  input  logic [7:0]               tx_data_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  output logic                     uart_o,
  output logic                     busy_o,
  output logic                     tx_done_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e              state, state_n;
  logic [DATA_BITS-1:0]   shift, shift_n, rot;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic                   stop_cnt, stop_cnt_n;
  logic                   uart_n;
  logic                   done_n;
  logic                   busy_n;
  logic                   load;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          count_next;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_BPS_i (clk_BPS_i),
    .rst_i     (rst_i),
    .push      (push),
    .wr_data   (tx_data_i),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready_o   = !fifo_full;
  assign fifo_count_o = fifo_count;
  assign push         = tx_valid_i && tx_ready_o;

  // Rotating rather than shifting leaves the original byte in place after eight bits,
  // so parity can be taken from the register directly.
  assign rot = {shift[0], shift[DATA_BITS-1:1]};

  // Occupancy after this edge, so busy_o can be registered without lagging the FIFO.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + ONE;
    end else if (!push && pop) begin
      count_next = fifo_count - ONE;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    uart_n     = IDLE_LEVEL;
    done_n     = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        load = !fifo_empty;
      end
      ST_START: begin
        uart_n    = shift[0];
        shift_n   = rot;
        bit_cnt_n = '0;
        state_n   = ST_DATA;
      end
      ST_DATA: begin
        if (bit_cnt == LAST_BIT) begin
          stop_cnt_n = 1'b0;
          if (PARITY_EN) begin
            uart_n  = even_parity(shift);
            state_n = ST_PARITY;
          end else begin
            uart_n  = IDLE_LEVEL;
            done_n  = (STOP_BITS == 1);
            state_n = ST_STOP;
          end
        end else begin
          uart_n    = shift[0];
          shift_n   = rot;
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      ST_PARITY: begin
        stop_cnt_n = 1'b0;
        done_n     = (STOP_BITS == 1);
        state_n    = ST_STOP;
      end
      ST_STOP: begin
        if (stop_cnt == LAST_STOP) begin
          state_n = ST_IDLE;
          load    = !fifo_empty;
        end else begin
          // At most two stop bits, so the cycle after the first is always the last.
          stop_cnt_n = 1'b1;
          done_n     = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (load) begin
      pop       = 1'b1;
      shift_n   = fifo_rd_data;
      bit_cnt_n = '0;
      uart_n    = START_LEVEL;
      state_n   = ST_START;
    end

    busy_n = (state_n != ST_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk_BPS_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      uart_o    <= IDLE_LEVEL;
      tx_done_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      uart_o    <= uart_n;
      tx_done_o <= done_n;
      busy_o    <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a default instance (1 stop, no parity) and a
// PARITY_EN=1 / STOP_BITS=2 instance, with the line logged one sample per bit period.
module tb_uart_transmitter;

  logic clk_BPS_i = 1'b0;
  always #5 clk_BPS_i = ~clk_BPS_i;

  logic       rst_i;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, uart, busy, tx_done;
  logic [2:0] fifo_count;

  logic [7:0] p_data;
  logic       p_valid;
  logic       p_ready, p_uart, p_busy, p_done;
  logic [2:0] p_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic       line_q[$];
  logic       done_q[$];
  logic       p_line_q[$];
  logic       p_done_q[$];
  logic [7:0] rx_q[$];
  int         rx_pos[$];
  logic       rx_stop[$];

  uart_transmitter #(.DEPTH(4), .STOP_BITS(1), .PARITY_EN(1'b0)) dut (
    .clk_BPS_i    (clk_BPS_i),
    .rst_i        (rst_i),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .uart_o       (uart),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .fifo_count_o (fifo_count)
  );

  uart_transmitter #(.DEPTH(4), .STOP_BITS(2), .PARITY_EN(1'b1)) dut_p (
    .clk_BPS_i    (clk_BPS_i),
    .rst_i        (rst_i),
    .tx_data_i    (p_data),
    .tx_valid_i   (p_valid),
    .tx_ready_o   (p_ready),
    .uart_o       (p_uart),
    .busy_o       (p_busy),
    .tx_done_o    (p_done),
    .fifo_count_o (p_count)
  );

  // Default frame as transmitted, index 0 first: start, data LSB-first, stop.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic int done_pulses();
    int n = 0;
    foreach (done_q[i]) if (done_q[i] === 1'b1) n++;
    return n;
  endfunction

  // One bit period: an active edge, then sample both lines 1 time unit later.
  task automatic step();
    @(posedge clk_BPS_i);
    #1;
    line_q.push_back(uart);
    done_q.push_back(tx_done);
    p_line_q.push_back(p_uart);
    p_done_q.push_back(p_done);
  endtask

  task automatic clear_logs();
    line_q.delete();
    done_q.delete();
    p_line_q.delete();
    p_done_q.delete();
  endtask

  // Bench-side receiver: find each start bit on an idle-high line and pull out the frame.
  task automatic decode_log();
    int i;
    logic [7:0] b;
    rx_q.delete();
    rx_pos.delete();
    rx_stop.delete();
    i = 0;
    while (i + 9 < line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + 1 + k];
        rx_q.push_back(b);
        rx_pos.push_back(i);
        rx_stop.push_back(line_q[i + 9]);
        i += 10;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    tx_valid = 1'b0;
    p_valid  = 1'b0;
    step();
    step();
    n_cmp++; if (uart !== 1'b1) begin n_bad++; $display("FAIL reset_uart: got %b expected 1", uart); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (p_uart !== 1'b1) begin n_bad++; $display("FAIL reset_uart_p: got %b expected 1", p_uart); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single_byte();
    logic [9:0] exp_line;
    exp_line = 10'b1010101010;
    clear_logs();
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
    n_cmp++; if (uart !== 1'b1) begin n_bad++; $display("FAIL single_idle_at_push: got %b expected 1", uart); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (uart !== exp_line[k-1]) begin n_bad++; $display("FAIL single_line bit %0d: got %b expected %b", k-1, uart, exp_line[k-1]); end
      n_cmp++; if (tx_done !== (k == 10)) begin n_bad++; $display("FAIL single_done cycle %0d: got %b expected %b", k, tx_done, (k == 10)); end
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    n_cmp++; if (uart !== 1'b1) begin n_bad++; $display("FAIL single_idle_after: got %b expected 1", uart); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL single_done_after: got %b expected 0", tx_done); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_line;
    int mism;
    exp_line = {frame_bits(8'h3C), frame_bits(8'hA5)};
    mism = 0;
    clear_logs();
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();
    tx_data  = 8'h3C;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 19; k++) step();
    for (int k = 1; k <= 20; k++) begin
      n_cmp++;
      if (line_q[k] !== exp_line[k-1]) begin
        n_bad++;
        $display("FAIL b2b_line bit %0d: got %b expected %b", k-1, line_q[k], exp_line[k-1]);
      end
    end
    n_cmp++; if (done_pulses() != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", done_pulses()); end
    n_cmp++; if (done_q[10] !== 1'b1 || done_q[20] !== 1'b1) begin n_bad++; $display("FAIL b2b_done_pos: got %b%b expected 11", done_q[10], done_q[20]); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [6];
    bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h99};
    clear_logs();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = bytes[i];
      step();
      if (i == 3) begin
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_at3: got %b expected 1", tx_ready); end
        n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL full_count_at3: got %0d expected 3", fifo_count); end
      end
      if (i == 4) begin
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_at4: got %b expected 0", tx_ready); end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count_at4: got %0d expected 4", fifo_count); end
      end
    end
    tx_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_count_ignored: got %0d expected 4", fifo_count); end
    for (int k = 0; k < 60; k++) step();
    decode_log();
    n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL full_frames: got %0d expected 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== bytes[i]) begin n_bad++; $display("FAIL full_byte %0d: got %h expected %h", i, rx_q[i], bytes[i]); end
      n_cmp++; if (rx_pos[i] != 1 + 10 * i) begin n_bad++; $display("FAIL full_pos %0d: got %0d expected %0d", i, rx_pos[i], 1 + 10 * i); end
      n_cmp++; if (rx_stop[i] !== 1'b1) begin n_bad++; $display("FAIL full_stop %0d: got %b expected 1", i, rx_stop[i]); end
    end
    n_cmp++; if (done_pulses() != 5) begin n_bad++; $display("FAIL full_done_count: got %0d expected 5", done_pulses()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int ones;
    clear_logs();
    tx_valid = 1'b1;
    tx_data  = 8'hC6;
    step();
    tx_data  = 8'h3A;
    step();
    tx_data  = 8'h9E;
    step();
    tx_valid = 1'b0;
    step();
    step();
    step();
    // Line now carries data bit 3 of 0xC6 (0), with two bytes still queued.
    n_cmp++; if (uart !== 1'b0) begin n_bad++; $display("FAIL midrst_bit3: got %b expected 0", uart); end
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL midrst_queued: got %0d expected 2", fifo_count); end
    rst_i = 1'b1;
    step();
    n_cmp++; if (uart !== 1'b1) begin n_bad++; $display("FAIL midrst_uart: got %b expected 1", uart); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", tx_ready); end
    rst_i = 1'b0;
    clear_logs();
    for (int k = 0; k < 25; k++) step();
    ones = 0;
    foreach (line_q[i]) if (line_q[i] === 1'b1) ones++;
    n_cmp++; if (ones != 25) begin n_bad++; $display("FAIL midrst_quiet_line: got %0d high samples expected 25", ones); end
    n_cmp++; if (done_pulses() != 0) begin n_bad++; $display("FAIL midrst_quiet_done: got %0d expected 0", done_pulses()); end
    clear_logs();
    tx_valid = 1'b1;
    tx_data  = 8'h0F;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 12; k++) step();
    decode_log();
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h0F) begin n_bad++; $display("FAIL midrst_new_push: got %0d frames first %h expected 1 frame 0f", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_parity_two_stop();
    logic [11:0] exp_line;
    exp_line = 12'b1110_0000_1110;
    clear_logs();
    p_data  = 8'h07;
    p_valid = 1'b1;
    step();
    p_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++; if (p_uart !== exp_line[k-1]) begin n_bad++; $display("FAIL parity_line bit %0d: got %b expected %b", k-1, p_uart, exp_line[k-1]); end
      n_cmp++; if (p_done !== (k == 12)) begin n_bad++; $display("FAIL parity_done cycle %0d: got %b expected %b", k, p_done, (k == 12)); end
    end
    step();
    n_cmp++; if (p_busy !== 1'b0) begin n_bad++; $display("FAIL parity_busy_after: got %b expected 0", p_busy); end
    n_cmp++; if (p_uart !== 1'b1) begin n_bad++; $display("FAIL parity_idle_after: got %b expected 1", p_uart); end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    clear_logs();
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = bytes[i];
      step();
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 42; k++) step();
    decode_log();
    n_cmp++; if (rx_q.size() != 4) begin n_bad++; $display("FAIL loop_frames: got %0d expected 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== bytes[i]) begin n_bad++; $display("FAIL loop_byte %0d: got %h expected %h", i, rx_q[i], bytes[i]); end
      n_cmp++; if (rx_pos[i] != 1 + 10 * i) begin n_bad++; $display("FAIL loop_pos %0d: got %0d expected %0d", i, rx_pos[i], 1 + 10 * i); end
      n_cmp++; if (rx_stop[i] !== 1'b1) begin n_bad++; $display("FAIL loop_stop %0d: got %b expected 1", i, rx_stop[i]); end
    end
    n_cmp++; if (done_pulses() != 4) begin n_bad++; $display("FAIL loop_done_count: got %0d expected 4", done_pulses()); end
  endtask

  initial begin
    rst_i    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    p_valid  = 1'b0;
    p_data   = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    test_parity_two_stop();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
